hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Stall/flush sequencer for the 5-stage pipeline.
- Detects data hazards that forwarding cannot cover, using Tuse/Tnew comparison.
- Sequences the multi-cycle multiply/divide unit: issues a start strobe, tracks busy time, and holds any HI/LO-using instruction in D until the unit is free.
- Drives the hold of PC and IF/ID, drives the clear (stall) input of the D/E pipeline registers to insert a bubble, and keeps a saturating stall-cycle counter.

Parameters:
MULT_LAT, 5, busy cycles for mult/multu (1 to 2^CNT_W-1)
DIV_LAT, 10, busy cycles for div/divu (1 to 2^CNT_W-1)
CNT_W, 4, width of the busy down-counter

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high
d_rs  in  5  D-stage rs index
d_rt  in  5  D-stage rt index
d_use_rs  in  1  D instruction reads rs
d_use_rt  in  1  D instruction reads rt
d_tuse_rs  in  2  cycles until rs is needed (0 = in D)
d_tuse_rt  in  2  cycles until rt is needed
d_is_md  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
e_wa  in  5  E-stage write register (0 = none)
e_tnew  in  2  cycles until E result is available
m_wa  in  5  M-stage write register
m_tnew  in  2  cycles until M result is available
e_mult  in  1  E instruction is mult/multu
e_div  in  1  E instruction is div/divu
stall_fd  out  1  hold PC and IF/ID
flush_de  out  1  clear D/E registers (bubble)
md_start  out  1  start strobe to the HI/LO datapath
md_busy  out  1  mult/div unit busy
md_done  out  1  one-cycle pulse after busy ends
stall_cnt  out  32  total stalled cycles, saturating

Behaviour:
- Reset values: md_busy=0, md_done=0, internal cnt=0, stall_cnt=0. stall_fd, flush_de and md_start follow from these and the inputs.
- Data hazard (combinational) for rs:
  - d_use_rs && d_rs!=0 && ((d_rs==e_wa && e_tnew>d_tuse_rs) || (d_rs==m_wa && m_tnew>d_tuse_rs)).
  - The same rule applies for rt.
  - A write register of 0 never matches.
- MD hazard (combinational): d_is_md && (md_busy || md_start).
- stall_fd = flush_de = data hazard OR MD hazard. Both are asserted in the same cycle with no latency.
- md_start = (e_mult || e_div) && !md_busy.
  - If both e_mult and e_div are set, e_div takes priority (DIV_LAT).
  - A start while md_busy is ignored: no reload and no strobe.
- MD FSM has two states, IDLE and BUSY:
  - IDLE: when md_start is high at a posedge, load cnt = the selected LAT and go to BUSY (md_busy=1).
  - BUSY: cnt decrements by 1 each posedge. When cnt==1 at a posedge, go to IDLE, set md_busy=0, and set md_done=1 for the next cycle only.
  - md_busy therefore stays high for exactly LAT cycles after the start edge.
- Boundary, last busy cycle: during the final busy cycle, a D-stage MD instruction is still stalled. It is released in the next cycle, the same cycle md_done is high.
- Boundary, new start with md_done high: a new start is allowed in the same cycle md_done is high (state is IDLE).
- stall_cnt: increments by 1 at each posedge where stall_fd==1. It holds at 0xFFFFFFFF and never wraps.
- Reset mid-operation: reset at any posedge forces IDLE, cnt=0, md_busy=0, md_done=0 and stall_cnt=0. Reset overrides a start in the same cycle.

Test Plan:
- Load-use: e_wa=5, e_tnew=2, d_rs=5, d_use_rs=1, d_tuse_rs=1 -> stall_fd=flush_de=1 this cycle. With e_tnew=1 -> 0. With d_rs=0 and e_wa=0 -> 0.
- Mult sequencing: e_mult=1 for 1 cycle -> md_start=1; md_busy=1 for exactly 5 cycles; md_done pulses in cycle 6. Hold d_is_md=1 throughout -> stall_fd=1 through the 5th busy cycle and 0 in cycle 6.
- Div priority and overlap: e_mult=e_div=1 -> md_busy for 10 cycles. A second e_mult at busy cycle 3 -> no md_start and no reload; busy still ends at cycle 10.
- Back-to-back: e_div asserted in the md_done cycle -> md_start=1, md_busy back high next cycle for 10 cycles.
- Reset mid-busy: reset at busy cycle 4 -> next cycle md_busy=0, md_done=0, stall_cnt=0. No md_done pulse follows.
- Counter: 7 stalled cycles -> stall_cnt=7. Force the value near saturation via a long stall run or model preload -> holds at 0xFFFFFFFF.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: D/E/M stage hazard inputs and the stall/flush/mult-div outputs.
// The pipeline side uses master, the hazard controller uses slave.
interface hazard_ctrl_if;
  logic [4:0]  d_rs;
  logic [4:0]  d_rt;
  logic        d_use_rs;
  logic        d_use_rt;
  logic [1:0]  d_tuse_rs;
  logic [1:0]  d_tuse_rt;
  logic        d_is_md;
  logic [4:0]  e_wa;
  logic [1:0]  e_tnew;
  logic [4:0]  m_wa;
  logic [1:0]  m_tnew;
  logic        e_mult;
  logic        e_div;
  logic        stall_fd;
  logic        flush_de;
  logic        md_start;
  logic        md_busy;
  logic        md_done;
  logic [31:0] stall_cnt;

  modport master (
    output d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt, d_is_md,
           e_wa, e_tnew, m_wa, m_tnew, e_mult, e_div,
    input  stall_fd, flush_de, md_start, md_busy, md_done, stall_cnt
  );

  modport slave (
    input  d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt, d_is_md,
           e_wa, e_tnew, m_wa, m_tnew, e_mult, e_div,
    output stall_fd, flush_de, md_start, md_busy, md_done, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: Tuse/Tnew data hazards,
// multiply/divide busy sequencing and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input logic         clk,
  input logic         reset,
  hazard_ctrl_if.slave hz
);

  typedef enum logic {IDLE, BUSY} md_state_t;

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_LAT);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             md_busy_q;
  logic             md_done_q;
  logic [31:0]      stall_cnt_q;

  logic haz_rs;
  logic haz_rt;
  logic md_start;
  logic md_haz;
  logic stall;

  // A source register stalls D when a producer in E or M will not have its
  // result ready by the time the consumer needs it; register 0 never matches.
  function automatic logic src_hazard(
    input logic [4:0] idx,
    input logic       use_src,
    input logic [1:0] tuse,
    input logic [4:0] e_wa,
    input logic [1:0] e_tnew,
    input logic [4:0] m_wa,
    input logic [1:0] m_tnew
  );
    return use_src && (idx != 5'd0) &&
           (((idx == e_wa) && (e_tnew > tuse)) ||
            ((idx == m_wa) && (m_tnew > tuse)));
  endfunction

  always_comb begin
    haz_rs   = src_hazard(hz.d_rs, hz.d_use_rs, hz.d_tuse_rs,
                          hz.e_wa, hz.e_tnew, hz.m_wa, hz.m_tnew);
    haz_rt   = src_hazard(hz.d_rt, hz.d_use_rt, hz.d_tuse_rt,
                          hz.e_wa, hz.e_tnew, hz.m_wa, hz.m_tnew);
    md_start = (hz.e_mult || hz.e_div) && !md_busy_q;
    md_haz   = hz.d_is_md && (md_busy_q || md_start);
    stall    = haz_rs || haz_rt || md_haz;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      md_busy_q   <= 1'b0;
      md_done_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      md_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (md_start) begin
            cnt       <= hz.e_div ? DIV_LD : MULT_LD;
            state     <= BUSY;
            md_busy_q <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt == CNT_W'(1)) begin
            cnt       <= '0;
            state     <= IDLE;
            md_busy_q <= 1'b0;
            md_done_q <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          md_busy_q <= 1'b0;
        end
      endcase
      if (stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign hz.stall_fd  = stall;
  assign hz.flush_de  = stall;
  assign hz.md_start  = md_start;
  assign hz.md_busy   = md_busy_q;
  assign hz.md_done   = md_done_q;
  assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl; a reference model pushes expected
// outputs into a queue and an independent monitor pops and compares them.
module tb_hazard_ctrl;

  localparam int unsigned MULT_LAT = 5;
  localparam int unsigned DIV_LAT  = 10;

  typedef struct {
    logic       rst;
    logic [4:0] d_rs, d_rt;
    logic       use_rs, use_rt;
    logic [1:0] tuse_rs, tuse_rt;
    logic       is_md;
    logic [4:0] e_wa;
    logic [1:0] e_tnew;
    logic [4:0] m_wa;
    logic [1:0] m_tnew;
    logic       e_mult, e_div;
  } stim_t;

  typedef struct {
    logic        stall;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if hz();

  hazard_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .hz(hz)
  );

  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  // Reference model state: cycles of busy time left, done flag, stall total.
  int unsigned busy_left = 0;
  bit          done_m = 1'b0;
  logic [31:0] sc_m = '0;

  function automatic bit src_haz(input logic [4:0] idx, input logic u, input logic [1:0] tuse,
                                 input stim_t s);
    if (!u || idx == 0) return 1'b0;
    if (idx == s.e_wa && int'(s.e_tnew) > int'(tuse)) return 1'b1;
    if (idx == s.m_wa && int'(s.m_tnew) > int'(tuse)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s.rst = 0; s.d_rs = 0; s.d_rt = 0; s.use_rs = 0; s.use_rt = 0;
    s.tuse_rs = 0; s.tuse_rt = 0; s.is_md = 0; s.e_wa = 0; s.e_tnew = 0;
    s.m_wa = 0; s.m_tnew = 0; s.e_mult = 0; s.e_div = 0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst     = ($urandom_range(0, 99) == 0);
    s.d_rs    = 5'($urandom_range(0, 3));
    s.d_rt    = 5'($urandom_range(0, 3));
    s.use_rs  = 1'($urandom_range(0, 1));
    s.use_rt  = 1'($urandom_range(0, 1));
    s.tuse_rs = 2'($urandom_range(0, 2));
    s.tuse_rt = 2'($urandom_range(0, 2));
    s.is_md   = ($urandom_range(0, 3) == 0);
    s.e_wa    = 5'($urandom_range(0, 3));
    s.e_tnew  = 2'($urandom_range(0, 2));
    s.m_wa    = 5'($urandom_range(0, 3));
    s.m_tnew  = 2'($urandom_range(0, 1));
    s.e_mult  = ($urandom_range(0, 7) == 0);
    s.e_div   = ($urandom_range(0, 11) == 0);
    return s;
  endfunction

  task automatic cycle(input stim_t s, input bit chk);
    exp_t e;
    @(negedge clk);
    reset        = s.rst;
    hz.d_rs      = s.d_rs;    hz.d_rt      = s.d_rt;
    hz.d_use_rs  = s.use_rs;  hz.d_use_rt  = s.use_rt;
    hz.d_tuse_rs = s.tuse_rs; hz.d_tuse_rt = s.tuse_rt;
    hz.d_is_md   = s.is_md;
    hz.e_wa      = s.e_wa;    hz.e_tnew    = s.e_tnew;
    hz.m_wa      = s.m_wa;    hz.m_tnew    = s.m_tnew;
    hz.e_mult    = s.e_mult;  hz.e_div     = s.e_div;
    #1;
    e.busy  = (busy_left != 0);
    e.done  = done_m;
    e.cnt   = sc_m;
    e.start = (s.e_mult || s.e_div) && !e.busy;
    e.stall = src_haz(s.d_rs, s.use_rs, s.tuse_rs, s) ||
              src_haz(s.d_rt, s.use_rt, s.tuse_rt, s) ||
              (s.is_md && (e.busy || e.start));
    if (chk) sb.push_back(e);
    @(posedge clk);
    if (s.rst) begin
      busy_left = 0; done_m = 0; sc_m = '0;
    end else begin
      done_m = (busy_left == 1);
      if (busy_left > 0) busy_left = busy_left - 1;
      else if (e.start) busy_left = s.e_div ? DIV_LAT : MULT_LAT;
      if (e.stall && sc_m != 32'hFFFF_FFFF) sc_m = sc_m + 1;
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, expv, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle, sampled 2 time units after negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("stall_fd",  32'(hz.stall_fd),  32'(e.stall));
        cmp("flush_de",  32'(hz.flush_de),  32'(e.stall));
        cmp("md_start",  32'(hz.md_start),  32'(e.start));
        cmp("md_busy",   32'(hz.md_busy),   32'(e.busy));
        cmp("md_done",   32'(hz.md_done),   32'(e.done));
        cmp("stall_cnt", hz.stall_cnt,      e.cnt);
      end
    end
  end

  initial begin
    stim_t s;
    reset = 1'b1;
    s = idle_stim(); s.rst = 1;
    cycle(s, 0);
    cycle(s, 1);
    s = idle_stim();
    cycle(s, 1);

    // Load-use: stall, then producer ready, then r0 never matches.
    s = idle_stim(); s.e_wa = 5; s.e_tnew = 2; s.d_rs = 5; s.use_rs = 1; s.tuse_rs = 1;
    cycle(s, 1);
    s.e_tnew = 1; cycle(s, 1);
    s.e_tnew = 2; s.d_rs = 0; s.e_wa = 0; cycle(s, 1);
    s = idle_stim(); s.m_wa = 7; s.m_tnew = 1; s.d_rt = 7; s.use_rt = 1; s.tuse_rt = 0;
    cycle(s, 1);

    // Mult with an MD instruction waiting in D.
    s = idle_stim(); s.is_md = 1; s.e_mult = 1; cycle(s, 1);
    s.e_mult = 0;
    for (int i = 0; i < 7; i++) cycle(s, 1);

    // Div priority, overlapping mult at busy cycle 3 ignored.
    s = idle_stim(); s.e_mult = 1; s.e_div = 1; cycle(s, 1);
    s = idle_stim(); cycle(s, 1); cycle(s, 1);
    s.e_mult = 1; cycle(s, 1);
    s.e_mult = 0;
    for (int i = 0; i < 20 && !done_m; i++) cycle(s, 1);
    // Back-to-back: new div in the md_done cycle.
    s.e_div = 1; cycle(s, 1);
    s.e_div = 0;
    for (int i = 0; i < 12; i++) cycle(s, 1);

    // Reset mid-busy with a concurrent start request.
    s = idle_stim(); s.e_mult = 1; cycle(s, 1);
    s.e_mult = 0; cycle(s, 1); cycle(s, 1); cycle(s, 1);
    s.rst = 1; s.e_div = 1; cycle(s, 1);
    s = idle_stim();
    for (int i = 0; i < 8; i++) cycle(s, 1);

    // Exactly 7 stalled cycles from a clean counter.
    s = idle_stim(); s.rst = 1; cycle(s, 1);
    s = idle_stim(); s.e_wa = 3; s.e_tnew = 2; s.d_rs = 3; s.use_rs = 1;
    for (int i = 0; i < 7; i++) cycle(s, 1);
    s = idle_stim(); cycle(s, 1); cycle(s, 1);

    for (int i = 0; i < 3000; i++) cycle(rand_stim(), 1);

    // Saturation: preload the counter just below the ceiling.
    s = idle_stim(); s.rst = 1; cycle(s, 1);
    #1;
    force dut.stall_cnt_q = 32'hFFFF_FFFC;
    release dut.stall_cnt_q;
    sc_m = 32'hFFFF_FFFC;
    s = idle_stim(); s.e_wa = 9; s.e_tnew = 1; s.d_rt = 9; s.use_rt = 1; s.tuse_rt = 0;
    for (int i = 0; i < 8; i++) cycle(s, 1);
    s = idle_stim(); cycle(s, 1); cycle(s, 1);

    @(negedge clk); #5;
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
